// File: rtl/piso_shifter.sv
// piso_shifter: valid/ready loaded parallel-in, serial-out unloader.
// Build option: define PISO_MSB_FIRST_EN to send MSB first.
module piso_shifter #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             bit_last,
  output logic             done
);

  localparam int BW = $clog2(WIDTH);
  localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic             done_q, done_d;

  logic             per_end;
  logic             word_end;
  logic             ser;
  logic [WIDTH-1:0] shifted;

  assign per_end  = (pcnt_q == PW'(CLKS_PER_BIT - 1));
  assign word_end = (bcnt_q == BW'(WIDTH - 1));

`ifdef PISO_MSB_FIRST_EN
  assign ser     = sreg_q[WIDTH-1];
  assign shifted = {sreg_q[WIDTH-2:0], 1'b0};
`else
  assign ser     = sreg_q[0];
  assign shifted = {1'b0, sreg_q[WIDTH-1:1]};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      bcnt_q  <= '0;
      pcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      bcnt_q  <= bcnt_d;
      pcnt_q  <= pcnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    bcnt_d  = bcnt_q;
    pcnt_d  = pcnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_valid) begin
          state_d = SHIFT;
          sreg_d  = load_data;
          bcnt_d  = '0;
          pcnt_d  = '0;
        end
      end
      SHIFT: begin
        if (per_end) begin
          pcnt_d = '0;
          sreg_d = shifted;
          bcnt_d = bcnt_q + BW'(1);
          // final bit period over: back to idle, pulse done
          if (word_end) begin
            state_d = IDLE;
            bcnt_d  = '0;
            done_d  = 1'b1;
          end
        end else begin
          pcnt_d = pcnt_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign load_ready = (state_q == IDLE);
  assign bit_valid  = (state_q == SHIFT);
  assign bit_out    = bit_valid & ser;
  assign bit_last   = bit_valid & word_end;
  assign done       = done_q;

endmodule

// File: tb/tb_piso_shifter.sv
// tb_piso_shifter: two instances (1 and 3 clocks per bit) on shared
// inputs, each compared cycle by cycle against a timeline model.
module tb_piso_shifter;

  localparam int W = 8;
  localparam int NOHS = -100000;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_data = '0;

  logic [1:0] rdy_w, bv_w, bo_w, bl_w, dn_w;

  int checks = 0;
  int errors = 0;
  int cur = 0;
  int hs [2] = '{NOHS, NOHS};
  logic [W-1:0] wd [2];

  always #5 clk = ~clk;

  piso_shifter #(.WIDTH(W), .CLKS_PER_BIT(1)) u_c1 (
    .clk(clk), .reset(reset), .load_valid(load_valid),
    .load_ready(rdy_w[0]), .load_data(load_data),
    .bit_out(bo_w[0]), .bit_valid(bv_w[0]),
    .bit_last(bl_w[0]), .done(dn_w[0])
  );

  piso_shifter #(.WIDTH(W), .CLKS_PER_BIT(3)) u_c3 (
    .clk(clk), .reset(reset), .load_valid(load_valid),
    .load_ready(rdy_w[1]), .load_data(load_data),
    .bit_out(bo_w[1]), .bit_valid(bv_w[1]),
    .bit_last(bl_w[1]), .done(dn_w[1])
  );

  // Expected outputs in the cycle following edge `cur`, from the
  // handshake edge and the bit-period arithmetic.
  function automatic void expv(input int d, output logic rdy,
                               output logic vld, output logic bo,
                               output logic lst, output logic dn);
    int c, e, k;
    c = (d == 0) ? 1 : 3;
    e = cur - hs[d] + 1;
    rdy = 1'b1; vld = 1'b0; bo = 1'b0; lst = 1'b0; dn = 1'b0;
    if (e >= 1 && e <= W * c) begin
      rdy = 1'b0;
      vld = 1'b1;
      k = (e - 1) / c;
`ifdef PISO_MSB_FIRST_EN
      bo = wd[d][W-1-k];
`else
      bo = wd[d][k];
`endif
      lst = (k == W - 1);
    end else if (e == W * c + 1) begin
      dn = 1'b1;
    end
  endfunction

  always @(posedge clk) begin
    logic r, v, b, l, n;
    for (int d = 0; d < 2; d++) begin
      expv(d, r, v, b, l, n);
      if (reset) hs[d] = NOHS;
      else if (r && load_valid) begin
        hs[d] = cur + 1;
        wd[d] = load_data;
      end
    end
    cur = cur + 1;
  end

  task automatic cmp(input string tag, input int d,
                     input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d cycle %0d observed %b expected %b",
             tag, d, cur, obs, exp);
    end
  endtask

  task automatic chk();
    logic r, v, b, l, n;
    for (int d = 0; d < 2; d++) begin
      expv(d, r, v, b, l, n);
      cmp("load_ready", d, rdy_w[d], r);
      cmp("bit_valid", d, bv_w[d], v);
      cmp("bit_out", d, bo_w[d], b);
      cmp("bit_last", d, bl_w[d], l);
      cmp("done", d, dn_w[d], n);
    end
  endtask

  // Check the cycle in progress, then set inputs for the next edge.
  task automatic step(input logic lv, input logic [W-1:0] ld,
                      input logic rs);
    @(negedge clk);
    chk();
    reset = rs;
    load_valid = lv;
    load_data = ld;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    step(1'b0, 8'h00, 1'b0);
    idle(6);

    step(1'b1, 8'hA5, 1'b0);
    idle(30);

    step(1'b1, 8'h81, 1'b0);
    idle(10);
    step(1'b0, 8'hFF, 1'b0);
    idle(20);

    step(1'b1, 8'h0F, 1'b0);
    for (int i = 0; i < 60; i++) step(1'b1, 8'hF0, 1'b0);
    idle(30);

    step(1'b1, 8'h3C, 1'b0);
    idle(4);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h01, 1'b0);
    idle(30);

    step(1'b1, 8'h80, 1'b0);
    idle(30);

    for (int i = 0; i < 400; i++)
      step(($urandom % 3) == 0, W'($urandom),
           ($urandom % 97) == 0);
    idle(30);

    @(negedge clk);
    chk();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
